ehl_fifo_wc: RTL
================

// Module: ehl_fifo_wc
// PURPOSE
//  Write-side controller of the dual-clock FIFO. It is the counterpart of the FIFO read controller.
//  - Owns the write pointer and per-bank write enables in the wclk domain.
//  - Publishes the Gray-coded write pointer to the read domain.
//  - Synchronizes the incoming read Gray pointer.
//  - Derives full, empty, almost-full, almost-empty and a sticky overflow flag.
// PARAMETERS
//  FIFO_ADR_WIDTH 2  Gray pointer width minus 1; equals $clog2(FIFO_DEPTH)
//  FIFO_CNT       1  number of memory banks; power of two
//  CS_WIDTH       1  bank-select output width; >= max(1,$clog2(FIFO_CNT))
//  WC_CNT         1  words per write; ==FIFO_CNT gives one-hot bank write, else all banks at once
//  RC_CNT         1  words per read on the far side; INCR = RC_CNT>1 ? RC_CNT : 1
//  FIFO_DEPTH     4  entries per bank; power of two; 1 allowed
//  SYNC_STAGES    2  flops on rptr_gray; 0 = bypass (pointer synchronized externally)
// PORTS
//  wclk        in   1                 write clock
//  reset       in   1                 asynchronous active-high reset
//  wr          in   1                 write request
//  clr_of      in   1                 clear sticky overflow
//  rptr_gray   in   FIFO_ADR_WIDTH+1  read Gray pointer (rclk domain)
//  wptr_gray   out  FIFO_ADR_WIDTH+1  registered write Gray pointer to read domain
//  waddr       out  FIFO_DEPTH==1?1:FIFO_ADR_WIDTH  memory row address
//  we          out  FIFO_CNT          per-bank write enable
//  cs_cnt      out  CS_WIDTH          bank select (waddr_bin LSBs; 0 if FIFO_CNT==1)
//  w_full, w_empty, w_afull, w_aempty  out 1 level flags
//  w_overflow  out  1                 sticky overflow
// BEHAVIOUR
//  - Reset (async, any time): waddr_bin=0, Gray counter=0, sync flops=0, w_overflow=0.
//    Resulting outputs: w_empty=1, w_full=0, we=0, waddr=0, cs_cnt=0.
//    A mid-operation reset discards contents; the read side must be reset together with it.
//  - Accepted write: acc = wr & !w_full.
//    - waddr_bin (FULL_AWIDTH+1 bits, FULL_AWIDTH=$clog2(FIFO_DEPTH*FIFO_CNT)) += INCR on acc; wraps modulo 2^(FULL_AWIDTH+1).
//    - we = acc ? bankmask : 0, combinational.
//    - bankmask = FIFO_CNT==1 ? 1 : (FIFO_CNT==WC_CNT ? 1<<waddr_bin[LSB-1:0] : all-ones).
//    - waddr = waddr_bin[LSB +: FIFO_ADR_WIDTH], or 0 when FIFO_DEPTH==1.
//  - Gray pointer: counter advances by 1 on acc & bankmask[FIFO_CNT-1] (row completed).
//    - Output is taken straight from the counter flop: no combinational Gray logic on the output.
//    - Successive values differ in exactly 1 bit.
//  - Read pointer: rptr_gray passes SYNC_STAGES wclk flops, then Gray-to-binary conversion gives rptr_bin.
//  - occ = waddr_bin - (rptr_bin << LSB), evaluated modulo 2^(FULL_AWIDTH+1).
//    - w_full = occ==FIFO_DEPTH*FIFO_CNT; w_afull = occ==FIFO_DEPTH*FIFO_CNT-INCR.
//    - w_empty = occ==0; w_aempty = occ==INCR.
//    - All flags are combinational from flops.
//  - Flag latency:
//    - A write that fills the FIFO raises w_full in the cycle after its accepting edge.
//    - A read frees space no earlier than SYNC_STAGES wclk edges after rptr_gray changes, so full is pessimistic.
//  - Overflow: on wr & w_full the write is dropped (no pointer or we change) and w_overflow=1 at the next edge.
//    - clr_of has priority over set.
//    - Non-synthesis builds print "Error: '%m' FIFO overflow" with the time.
//  - Simultaneous write and read-pointer update: both take effect; occ stays consistent and never exceeds capacity.
// STRUCTURE
//  - Shared package: FULL_AWIDTH, LSB (= $clog2(FIFO_CNT)), INCR, Gray<->binary functions.
//    The read controller uses the same package.
//  - Sub-modules:
//    - Reuse ehl_gray_cnt for wptr_gray.
//    - Reuse ehl_gray2bin for rptr_bin.
//    - One new sub-module, ehl_sync_vec: SYNC_STAGES-deep vector synchronizer with active-high async reset.
// TESTING (defaults unless stated)
//  1 reset=1 mid-burst -> same cycle: wptr_gray=000, waddr=0, we=0, w_empty=1, w_full=0, w_overflow=0.
//  2 rptr_gray=000, 4 writes -> waddr 0,1,2,3.
//    wptr_gray 001,011,010,110.
//    w_afull after 3rd write, w_full after 4th.
//  3 5th write while full -> we=0, wptr_gray stays 110, w_overflow=1.
//    clr_of=1 -> 0.
//    clr_of together with wr&w_full -> stays 0.
//  4 full, rptr_gray 000->001 -> w_full drops exactly 2 wclk edges later; SYNC_STAGES=0 -> same cycle.
//  5 16 interleaved write/read-pointer steps -> wptr_gray wraps 100->000.
//    w_empty=1 whenever synchronized rptr equals wptr.
//    No spurious full at wrap.
//  6 FIFO_CNT=2, WC_CNT=2, FIFO_DEPTH=4 -> we 01,10,01,10 and cs_cnt 0,1,0,1.
//    wptr_gray steps only on 2nd and 4th write.
//    w_full after 8 writes.

Source files
------------

// File: rtl/ehl_fifo_wc_pkg.sv
// rtl/ehl_fifo_wc_pkg.sv - shared pointer-width helpers and Gray/binary conversion for the FIFO controllers
package ehl_fifo_wc_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic int full_awidth(input int depth, input int cnt);
    return $clog2(depth * cnt);
  endfunction

  function automatic int lsb_width(input int cnt);
    return $clog2(cnt);
  endfunction

  function automatic int incr_of(input int rc_cnt);
    return (rc_cnt > 1) ? rc_cnt : 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ehl_fifo_wc_sync.sv
// rtl/ehl_fifo_wc_sync.sv - vector synchronizer with configurable depth; zero stages is a bypass
module ehl_sync_vec #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = clk ^ rst;
      assign q = d;
    end else begin : g_sync
      logic [WIDTH-1:0] stage_q [STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d;
          for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/ehl_gray2bin.sv
// rtl/ehl_gray2bin.sv - combinational Gray-to-binary converter
module ehl_gray2bin
  import ehl_fifo_wc_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/ehl_gray_cnt.sv
// rtl/ehl_gray_cnt.sv - Gray counter whose output comes straight from a flop
module ehl_gray_cnt
  import ehl_fifo_wc_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_nxt;

  assign bin_nxt = bin_q + WIDTH'(1);

  // Gray value is precomputed from the next binary so the output carries no glitchy logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      gray  <= '0;
    end else if (en) begin
      bin_q <= bin_nxt;
      gray  <= WIDTH'(bin2gray(GRAY_MAX_W'(bin_nxt)));
    end
  end

endmodule

// File: rtl/ehl_fifo_wc.sv
// rtl/ehl_fifo_wc.sv - write-side controller of the dual-clock FIFO: pointers, bank enables, level flags
module ehl_fifo_wc
  import ehl_fifo_wc_pkg::*;
#(
  parameter int FIFO_ADR_WIDTH = 2,
  parameter int FIFO_CNT       = 1,
  parameter int CS_WIDTH       = 1,
  parameter int WC_CNT         = 1,
  parameter int RC_CNT         = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                                      wclk,
  input  logic                                      reset,
  input  logic                                      wr,
  input  logic                                      clr_of,
  input  logic [FIFO_ADR_WIDTH:0]                   rptr_gray,
  output logic [FIFO_ADR_WIDTH:0]                   wptr_gray,
  output logic [(FIFO_DEPTH==1 ? 1 : FIFO_ADR_WIDTH)-1:0] waddr,
  output logic [FIFO_CNT-1:0]                       we,
  output logic [CS_WIDTH-1:0]                       cs_cnt,
  output logic                                      w_full,
  output logic                                      w_empty,
  output logic                                      w_afull,
  output logic                                      w_aempty,
  output logic                                      w_overflow
);

  localparam int FAW  = full_awidth(FIFO_DEPTH, FIFO_CNT);
  localparam int LSB  = lsb_width(FIFO_CNT);
  localparam int INCR = incr_of(RC_CNT);
  localparam int GW   = FIFO_ADR_WIDTH + 1;
  localparam bit ONE_HOT = (FIFO_CNT > 1) && (FIFO_CNT == WC_CNT);

  localparam logic [FAW:0] CAP_V    = (FAW+1)'(FIFO_DEPTH * FIFO_CNT);
  localparam logic [FAW:0] INCR_V   = (FAW+1)'(INCR);
  localparam logic [FAW:0] AFULL_V  = (FAW+1)'(FIFO_DEPTH * FIFO_CNT - INCR);

  logic [FAW:0]          waddr_bin;
  logic [FAW:0]          occ;
  logic [GW-1:0]         rptr_sync;
  logic [GW-1:0]         rptr_bin;
  logic [FIFO_CNT-1:0]   bankmask;
  logic                  acc;

  // Writes are blocked during reset so we is quiet even while wr is still asserted.
  assign acc = wr & ~w_full & ~reset;
  assign we  = acc ? bankmask : '0;

  generate
    if (FIFO_CNT == 1) begin : g_single
      assign bankmask = '1;
      assign cs_cnt   = '0;
    end else begin : g_banked
      logic [LSB-1:0] bank_sel;
      assign bank_sel = waddr_bin[LSB-1:0];
      assign bankmask = ONE_HOT ? (FIFO_CNT'(1) << bank_sel) : '1;
      assign cs_cnt   = CS_WIDTH'(bank_sel);
    end

    if (FIFO_DEPTH == 1) begin : g_one_row
      assign waddr = '0;
    end else begin : g_rows
      assign waddr = waddr_bin[LSB +: FIFO_ADR_WIDTH];
    end
  endgenerate

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      waddr_bin <= '0;
    end else if (acc) begin
      waddr_bin <= waddr_bin + INCR_V;
    end
  end

  // The published pointer counts rows, so it only advances once the last bank is written.
  ehl_gray_cnt #(.WIDTH(GW)) u_wptr (
    .clk  (wclk),
    .rst  (reset),
    .en   (acc & bankmask[FIFO_CNT-1]),
    .gray (wptr_gray)
  );

  ehl_sync_vec #(.WIDTH(GW), .STAGES(SYNC_STAGES)) u_rptr_sync (
    .clk (wclk),
    .rst (reset),
    .d   (rptr_gray),
    .q   (rptr_sync)
  );

  ehl_gray2bin #(.WIDTH(GW)) u_rptr_bin (
    .gray (rptr_sync),
    .bin  (rptr_bin)
  );

  assign occ      = waddr_bin - ((FAW+1)'(rptr_bin) << LSB);
  assign w_full   = (occ == CAP_V);
  assign w_afull  = (occ == AFULL_V);
  assign w_empty  = (occ == '0);
  assign w_aempty = (occ == INCR_V);

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      w_overflow <= 1'b0;
    end else if (clr_of) begin
      w_overflow <= 1'b0;
    end else if (wr && w_full) begin
      w_overflow <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge wclk) begin
    if (!reset && wr && w_full) $display("Error: '%m' FIFO overflow at %0t", $time);
  end
`endif

endmodule
